// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared bus constants for the Wishbone-style interconnect:
//               data width, slot count, slave index map, bus error pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DW      = 32;
    localparam int NUM_SLAVES = 16;

    // Fixed slot assignment of the memory-mapped peripherals
    localparam int SLV_RAM     = 0;
    localparam int SLV_DISK    = 1;
    localparam int SLV_VRAM    = 2;
    localparam int SLV_KBD     = 3;
    localparam int SLV_COUNTER = 4;

    // Read data returned to the master when a transaction times out
    localparam logic [WB_DW-1:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect
// Description : Single-master, multi-slave Wishbone-style interconnect.
//               Decodes the master address into a one-hot slave strobe,
//               latches the selected slot for the whole transaction, muxes the
//               selected ACK/read data back, and ends unacknowledged
//               transactions with a timeout bus error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_interconnect #(
    parameter int NUM_SLAVES = wb_pkg::NUM_SLAVES,
    parameter int SEL_MSB    = 31,
    parameter int SEL_LSB    = 28,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     master_STB,
    input  logic                     master_WE,
    input  logic [31:0]              master_ADDR,
    input  logic [31:0]              master_DAT_I,
    output logic [31:0]              master_DAT_O,
    output logic                     master_ACK,
    output logic                     master_ERR,
    output logic [NUM_SLAVES-1:0]    slave_STB,
    input  logic [NUM_SLAVES-1:0]    slave_ACK,
    output logic                     slave_WE,
    output logic [31:0]              slave_ADDR,
    output logic [31:0]              slave_DAT_O,
    input  logic [32*NUM_SLAVES-1:0] slave_DAT_I
);

    import wb_pkg::*;

    localparam int SEL_W = SEL_MSB - SEL_LSB + 1;

    // Timer is 8 bits; when the timeout is disabled it simply saturates at all-ones
    localparam logic       c_to_en     = (TIMEOUT != 0);
    localparam logic [7:0] c_timeout   = TIMEOUT[7:0];
    localparam logic [7:0] c_timer_max = c_to_en ? c_timeout : 8'hFF;

    logic             r_busy;
    logic [SEL_W-1:0] r_sel_q;
    logic [7:0]       r_timer;

    logic [SEL_W-1:0] w_sel;
    logic [31:0]      w_sel_ext;
    logic             w_mapped;
    logic             w_slave_ack;
    logic [31:0]      w_slave_dat;
    logic             w_timeout_hit;

    // Slot index: frozen once a transaction is in flight, else taken from the address
    assign w_sel     = r_busy ? r_sel_q : master_ADDR[SEL_MSB:SEL_LSB];
    assign w_sel_ext = {{(32-SEL_W){1'b0}}, w_sel};

    // Pick the selected slot's ACK and read data; unmapped slots read as no-ACK/zero
    always_comb begin
        w_mapped    = 1'b0;
        w_slave_ack = 1'b0;
        w_slave_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_sel_ext == i) begin
                w_mapped    = 1'b1;
                w_slave_ack = slave_ACK[i];
                w_slave_dat = slave_DAT_I[32*i +: 32];
            end
        end
    end

    // A late ACK beats the timeout when both land in the same cycle
    assign w_timeout_hit = r_busy & c_to_en & (r_timer == c_timeout) & ~w_slave_ack;

    // One-hot strobe to the selected slot, withdrawn in the timeout cycle
    always_comb begin
        slave_STB = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slave_STB[i] = master_STB & ~w_timeout_hit & w_mapped & (w_sel_ext == i);
        end
    end

    assign slave_WE    = master_STB & master_WE;
    assign slave_ADDR  = master_ADDR;
    assign slave_DAT_O = master_DAT_I;

    assign master_ACK = master_STB & (w_slave_ack | w_timeout_hit);
    assign master_ERR = master_STB & w_timeout_hit;

    // Read data back to the master: slave data on ACK, error pattern on timeout
    always_comb begin
        master_DAT_O = '0;
        if (master_STB && w_slave_ack) begin
            master_DAT_O = w_slave_dat;
        end else if (master_STB && w_timeout_hit) begin
            master_DAT_O = BUS_ERR_DATA;
        end
    end

    // Transaction tracking: latch slot on a multi-cycle request, count until ACK/timeout/abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_sel_q <= '0;
            r_timer <= '0;
        end else if (!r_busy) begin
            if (master_STB && !w_slave_ack) begin
                r_busy  <= 1'b1;
                r_sel_q <= w_sel;
                r_timer <= 8'd1;
            end
        end else begin
            if (w_slave_ack || w_timeout_hit || !master_STB) begin
                r_busy  <= 1'b0;
                r_timer <= '0;
            end else if (r_timer != c_timer_max) begin
                r_timer <= r_timer + 8'd1;
            end
        end
    end

endmodule : wb_interconnect
`default_nettype wire

// File: tb/tb_wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_interconnect
// Description : Directed self-checking bench for wb_interconnect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_interconnect;

    localparam int NS = 16;

    logic           clk;
    logic           rst;
    logic           master_STB;
    logic           master_WE;
    logic [31:0]    master_ADDR;
    logic [31:0]    master_DAT_I;
    logic [31:0]    master_DAT_O;
    logic           master_ACK;
    logic           master_ERR;
    logic [NS-1:0]  slave_STB;
    logic [NS-1:0]  slave_ACK;
    logic           slave_WE;
    logic [31:0]    slave_ADDR;
    logic [31:0]    slave_DAT_O;
    logic [32*NS-1:0] slave_DAT_I;

    int checks;
    int failures;

    wb_interconnect #(
        .NUM_SLAVES (NS),
        .SEL_MSB    (31),
        .SEL_LSB    (28),
        .TIMEOUT    (255)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .master_STB   (master_STB),
        .master_WE    (master_WE),
        .master_ADDR  (master_ADDR),
        .master_DAT_I (master_DAT_I),
        .master_DAT_O (master_DAT_O),
        .master_ACK   (master_ACK),
        .master_ERR   (master_ERR),
        .slave_STB    (slave_STB),
        .slave_ACK    (slave_ACK),
        .slave_WE     (slave_WE),
        .slave_ADDR   (slave_ADDR),
        .slave_DAT_O  (slave_DAT_O),
        .slave_DAT_I  (slave_DAT_I)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        master_STB   = 1'b0;
        master_WE    = 1'b0;
        master_ADDR  = '0;
        master_DAT_I = '0;
        slave_ACK    = '0;
        slave_DAT_I  = '0;

        step();
        step();
        rst = 1'b0;
        settle();
        // Reset / idle outputs
        check_val("rst_stb",  32'(slave_STB),  32'h0);
        check_val("rst_ack",  32'(master_ACK), 32'h0);
        check_val("rst_err",  32'(master_ERR), 32'h0);
        check_val("rst_dat",  master_DAT_O,    32'h0);

        // Single-cycle read from slot 2
        step();
        master_ADDR = 32'h2000_0010;
        master_STB  = 1'b1;
        slave_ACK   = 16'h0004;
        slave_DAT_I[32*2 +: 32] = 32'h1234_5678;
        slave_DAT_I[32*3 +: 32] = 32'h3333_3333;
        settle();
        check_val("rd1_stb", 32'(slave_STB),  32'h0004);
        check_val("rd1_ack", 32'(master_ACK), 32'h1);
        check_val("rd1_dat", master_DAT_O,    32'h1234_5678);
        check_val("rd1_we",  32'(slave_WE),   32'h0);

        // STB held: new decode from current address proves nothing was latched
        step();
        master_ADDR = 32'h3000_0000;
        slave_ACK   = '0;
        settle();
        check_val("b2b_stb", 32'(slave_STB),  32'h0008);
        check_val("b2b_ack", 32'(master_ACK), 32'h0);

        // Master abort: no strobe in the dropped cycle
        step();
        master_STB = 1'b0;
        settle();
        check_val("abort_stb", 32'(slave_STB),  32'h0);
        check_val("abort_ack", 32'(master_ACK), 32'h0);

        // Multi-cycle write to slot 4, address changes mid-transaction
        step();
        master_ADDR  = 32'h4000_0000;
        master_DAT_I = 32'hA5A5_A5A5;
        master_WE    = 1'b1;
        master_STB   = 1'b1;
        slave_DAT_I[32*1 +: 32] = 32'h1111_1111;
        slave_DAT_I[32*4 +: 32] = 32'hCAFE_0004;
        settle();
        check_val("wr_c1_stb", 32'(slave_STB),  32'h0010);
        check_val("wr_c1_we",  32'(slave_WE),   32'h1);
        check_val("wr_c1_dat", slave_DAT_O,     32'hA5A5_A5A5);
        check_val("wr_c1_ack", 32'(master_ACK), 32'h0);
        step();
        master_ADDR = 32'h1000_0000;
        settle();
        check_val("wr_c2_stb",  32'(slave_STB),  32'h0010);
        check_val("wr_c2_addr", slave_ADDR,      32'h1000_0000);
        check_val("wr_c2_ack",  32'(master_ACK), 32'h0);
        step();
        settle();
        check_val("wr_c3_stb", 32'(slave_STB),  32'h0010);
        check_val("wr_c3_ack", 32'(master_ACK), 32'h0);
        step();
        slave_ACK = 16'h0010;
        settle();
        check_val("wr_c4_stb", 32'(slave_STB),  32'h0010);
        check_val("wr_c4_ack", 32'(master_ACK), 32'h1);
        check_val("wr_c4_dat", master_DAT_O,    32'hCAFE_0004);
        step();
        master_STB = 1'b0;
        master_WE  = 1'b0;
        slave_ACK  = '0;
        settle();
        check_val("wr_end_ack", 32'(master_ACK), 32'h0);

        // Timeout on slot 7 (never acknowledges)
        step();
        master_ADDR = 32'h7000_0000;
        master_STB  = 1'b1;
        settle();
        check_val("to_c1_stb", 32'(slave_STB), 32'h0080);
        for (int c = 2; c <= 255; c++) step();
        settle();
        check_val("to_c255_ack", 32'(master_ACK), 32'h0);
        check_val("to_c255_stb", 32'(slave_STB),  32'h0080);
        step();
        settle();
        check_val("to_c256_ack", 32'(master_ACK), 32'h1);
        check_val("to_c256_err", 32'(master_ERR), 32'h1);
        check_val("to_c256_dat", master_DAT_O,    32'hFFFF_FFFF);
        check_val("to_c256_stb", 32'(slave_STB),  32'h0);

        // Next request serviced normally
        step();
        master_ADDR = 32'h0000_0000;
        slave_ACK   = 16'h0001;
        slave_DAT_I[32*0 +: 32] = 32'hDEAD_0000;
        settle();
        check_val("post_to_ack", 32'(master_ACK), 32'h1);
        check_val("post_to_err", 32'(master_ERR), 32'h0);
        check_val("post_to_dat", master_DAT_O,    32'hDEAD_0000);
        check_val("post_to_stb", 32'(slave_STB),  32'h0001);

        // ACK coinciding with the timeout cycle wins
        step();
        master_ADDR = 32'h5000_0000;
        slave_ACK   = '0;
        slave_DAT_I[32*5 +: 32] = 32'h5555_0005;
        for (int c = 2; c <= 256; c++) step();
        slave_ACK = 16'h0020;
        settle();
        check_val("race_ack", 32'(master_ACK), 32'h1);
        check_val("race_err", 32'(master_ERR), 32'h0);
        check_val("race_dat", master_DAT_O,    32'h5555_0005);
        check_val("race_stb", 32'(slave_STB),  32'h0020);

        // Non-selected ACK is ignored
        step();
        master_STB = 1'b0;
        slave_ACK  = '0;
        step();
        master_ADDR = 32'h1000_0000;
        master_STB  = 1'b1;
        settle();
        check_val("ign_c1_stb", 32'(slave_STB), 32'h0002);
        step();
        master_ADDR = 32'h3000_0000;
        slave_ACK   = 16'h0008;
        settle();
        check_val("ign_ack", 32'(master_ACK), 32'h0);
        check_val("ign_stb", 32'(slave_STB),  32'h0002);
        check_val("ign_dat", master_DAT_O,    32'h0);

        // Asynchronous reset while busy on slot 1
        step();
        slave_ACK   = '0;
        master_ADDR = 32'h0000_0000;
        settle();
        check_val("prerst_stb", 32'(slave_STB), 32'h0002);
        rst = 1'b1;
        settle();
        check_val("rst_busy_stb", 32'(slave_STB),  32'h0001);
        check_val("rst_busy_ack", 32'(master_ACK), 32'h0);
        step();
        rst        = 1'b0;
        master_STB = 1'b0;
        settle();
        check_val("final_stb", 32'(slave_STB), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_interconnect
`default_nettype wire
